// File: rtl/seu_npu_pkg.sv
// Shared types and constants for the NPU event-transmit CDC path.
package seu_npu_pkg;

  localparam int unsigned NCH_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } ch_state_e;

  localparam int unsigned CAL_START        = 0;
  localparam int unsigned IFM_RST          = 1;
  localparam int unsigned WT_RST           = 2;
  localparam int unsigned FIRST_BN         = 3;
  localparam int unsigned LAST_BN          = 4;
  localparam int unsigned TX_OFM_DONE      = 5;
  localparam int unsigned FT_LYR_PARA_DONE = 6;

endpackage

// File: rtl/seu_npu_evt_tx_ch.sv
// One event channel: ack synchronizer, four-phase req/ack FSM, pending counter, sticky ovf.
// SEU_NPU_EVT_TX_QUEUE_EN enables the pending-event counter; otherwise busy-time pulses drop.
module seu_npu_evt_tx_ch
  import seu_npu_pkg::*;
#(
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic             clk_trans,
  input  logic             rst_n,
  input  logic             evt_pulse,
  input  logic             ack_async,
  input  logic             ovf_clr,
  output logic             req_lvl,
  output logic             busy,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf
);

  ch_state_e           state_q, state_d;
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;
  logic                ack_s;
  logic                inc;
  logic                drop;
`ifdef SEU_NPU_EVT_TX_QUEUE_EN
  logic [CNT_W-1:0]    pend_q, pend_d;
  logic                dec;
`endif

  assign ack_s = sync_q[SYNC_STG-1];

  // Next-state, pending bookkeeping and overflow flag.
  always_comb begin
    sync_d  = {sync_q[SYNC_STG-2:0], ack_async};
    state_d = state_q;
    inc     = 1'b0;
    drop    = 1'b0;
`ifdef SEU_NPU_EVT_TX_QUEUE_EN
    pend_d  = pend_q;
    dec     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // A stale ack left over from before reset must clear before a new request.
        if (!ack_s) begin
          if (evt_pulse) begin
            state_d = ST_REQ;
          end
`ifdef SEU_NPU_EVT_TX_QUEUE_EN
          else if (pend_q != '0) begin
            state_d = ST_REQ;
            dec     = 1'b1;
          end
`endif
        end else begin
          inc = evt_pulse;
        end
      end
      ST_REQ: begin
        inc = evt_pulse;
        if (ack_s) begin
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        if (!ack_s) begin
`ifdef SEU_NPU_EVT_TX_QUEUE_EN
          if (pend_q != '0) begin
            state_d = ST_REQ;
            dec     = 1'b1;
            inc     = evt_pulse;
          end else if (evt_pulse) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
          inc     = evt_pulse;
`endif
        end else begin
          inc = evt_pulse;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef SEU_NPU_EVT_TX_QUEUE_EN
    if (inc && !dec) begin
      if (pend_q == '1) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - CNT_W'(1);
    end
`else
    drop = inc;
`endif

    ovf_d  = (ovf_q & ~ovf_clr) | drop;
    req_d  = (state_d == ST_REQ);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_trans or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SEU_NPU_EVT_TX_QUEUE_EN
      pend_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
`ifdef SEU_NPU_EVT_TX_QUEUE_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign req_lvl = req_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
`ifdef SEU_NPU_EVT_TX_QUEUE_EN
  assign pend_cnt = pend_q;
`else
  assign pend_cnt = '0;
`endif

endmodule

// File: rtl/seu_npu_evt_tx.sv
// NPU event transmitter: NCH independent pulse-to-handshake channels.
// SEU_NPU_EVT_TX_QUEUE_EN selects per-channel event queueing.
module seu_npu_evt_tx
  import seu_npu_pkg::*;
#(
  parameter int unsigned NCH      = NCH_DEF,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic                 clk_trans,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       evt_pulse,
  input  logic [NCH-1:0]       ack_async,
  output logic [NCH-1:0]       req_lvl,
  output logic [NCH-1:0]       busy,
  output logic [NCH*CNT_W-1:0] pend_cnt,
  output logic [NCH-1:0]       ovf,
  input  logic                 ovf_clr
);

  // One channel per event; ovf_clr fans out to all of them.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    seu_npu_evt_tx_ch #(
      .CNT_W   (CNT_W),
      .SYNC_STG(SYNC_STG)
    ) u_ch (
      .clk_trans(clk_trans),
      .rst_n    (rst_n),
      .evt_pulse(evt_pulse[i]),
      .ack_async(ack_async[i]),
      .ovf_clr  (ovf_clr),
      .req_lvl  (req_lvl[i]),
      .busy     (busy[i]),
      .pend_cnt (pend_cnt[i*CNT_W +: CNT_W]),
      .ovf      (ovf[i])
    );
  end

endmodule

// File: tb/tb_seu_npu_evt_tx.sv
// Self-checking bench for seu_npu_evt_tx with a 2-flop receiver model on a separate clock.
module tb_seu_npu_evt_tx;
  import seu_npu_pkg::*;

  localparam int unsigned NCH      = 7;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned SYNC_STG = 2;
  localparam int unsigned PMAX     = (1 << CNT_W) - 1;
`ifdef SEU_NPU_EVT_TX_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  logic clk_trans = 1'b0;
  logic rx_clk    = 1'b0;
  logic rst_n;
  logic ovf_clr;
  logic [NCH-1:0] evt_pulse, ack_async, req_lvl, busy, ovf;
  logic [NCH*CNT_W-1:0] pend_cnt;
  logic [NCH-1:0] stall, ack_frc;
  logic [NCH-1:0] rx_s1 = '0, rx_s2 = '0, rx_s2_d = '0;
  int unsigned edge_cnt [NCH] = '{default: 0};
  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk_trans = ~clk_trans;
  always #7 rx_clk = ~rx_clk;

  // Receiver: ack is its synchronized copy of req, unless the bench forces it.
  assign ack_async = (stall & ack_frc) | (~stall & rx_s2);

  always @(posedge rx_clk) begin
    rx_s1   <= req_lvl;
    rx_s2   <= rx_s1;
    rx_s2_d <= rx_s2;
    for (int i = 0; i < NCH; i++)
      if (rx_s2[i] && !rx_s2_d[i]) edge_cnt[i] <= edge_cnt[i] + 1;
  end

  seu_npu_evt_tx #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STG(SYNC_STG)) dut (
    .clk_trans(clk_trans), .rst_n(rst_n), .evt_pulse(evt_pulse),
    .ack_async(ack_async), .req_lvl(req_lvl), .busy(busy),
    .pend_cnt(pend_cnt), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  function automatic int unsigned get_pend(input int ch);
    return 32'(pend_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic tick();
    @(posedge clk_trans);
    #1;
  endtask

  task automatic pulse(input int ch);
    evt_pulse[ch] = 1'b1;
    tick();
    evt_pulse[ch] = 1'b0;
  endtask

  task automatic clr_pulse();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  // Hand the channel to the receiver model and wait for it to go quiet.
  task automatic drain(input int ch);
    int n = 0;
    stall[ch] = 1'b0;
    while ((busy[ch] || req_lvl[ch]) && n < 500) begin tick(); n++; end
    if (n >= 500) begin $display("FAIL drain_timeout ch=%0d busy=%0b req=%0b", ch, busy[ch], req_lvl[ch]); n_mis++; end
    n_cmp++;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; evt_pulse = '0; ovf_clr = 1'b0; stall = '0; ack_frc = '0;
    #1;
    if (req_lvl !== '0) begin $display("FAIL reset_req act=%0h exp=0", req_lvl); n_mis++; end n_cmp++;
    if (busy !== '0) begin $display("FAIL reset_busy act=%0h exp=0", busy); n_mis++; end n_cmp++;
    if (pend_cnt !== '0) begin $display("FAIL reset_pend act=%0h exp=0", pend_cnt); n_mis++; end n_cmp++;
    if (ovf !== '0) begin $display("FAIL reset_ovf act=%0h exp=0", ovf); n_mis++; end n_cmp++;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    if ({req_lvl, busy, ovf} !== '0) begin $display("FAIL post_reset act=%0h exp=0", {req_lvl, busy, ovf}); n_mis++; end n_cmp++;
  endtask

  task automatic test_single();
    int ch = CAL_START;
    int n = 0;
    int unsigned e0 = edge_cnt[ch];
    repeat (5) tick();
    if (req_lvl[ch] !== 1'b0) begin $display("FAIL single_pre_req act=%0b exp=0", req_lvl[ch]); n_mis++; end n_cmp++;
    pulse(ch);
    if (req_lvl[ch] !== 1'b1) begin $display("FAIL single_req act=%0b exp=1", req_lvl[ch]); n_mis++; end n_cmp++;
    if (busy[ch] !== 1'b1) begin $display("FAIL single_busy act=%0b exp=1", busy[ch]); n_mis++; end n_cmp++;
    while (req_lvl[ch] && n < 200) begin tick(); n++; end
    if (n >= 200) begin $display("FAIL single_req_fall_timeout act=1 exp=0"); n_mis++; end n_cmp++;
    if (busy[ch] !== 1'b1) begin $display("FAIL single_busy_rel act=%0b exp=1", busy[ch]); n_mis++; end n_cmp++;
    drain(ch);
    if (edge_cnt[ch] - e0 !== 1) begin $display("FAIL single_edges act=%0d exp=1", edge_cnt[ch] - e0); n_mis++; end n_cmp++;
    if (ovf[ch] !== 1'b0) begin $display("FAIL single_ovf act=%0b exp=0", ovf[ch]); n_mis++; end n_cmp++;
  endtask

  task automatic test_ack_latency();
    int ch = IFM_RST;
    stall[ch] = 1'b1; ack_frc[ch] = 1'b0;
    pulse(ch);
    repeat (3) tick();
    if (req_lvl[ch] !== 1'b1) begin $display("FAIL lat_req_hold act=%0b exp=1", req_lvl[ch]); n_mis++; end n_cmp++;
    ack_frc[ch] = 1'b1;
    repeat (2) tick();
    if (req_lvl[ch] !== 1'b1) begin $display("FAIL lat_ack_early act=%0b exp=1", req_lvl[ch]); n_mis++; end n_cmp++;
    tick();
    if (req_lvl[ch] !== 1'b0) begin $display("FAIL lat_ack_seen act=%0b exp=0", req_lvl[ch]); n_mis++; end n_cmp++;
    ack_frc[ch] = 1'b0;
    repeat (2) tick();
    if (busy[ch] !== 1'b1) begin $display("FAIL lat_busy_early act=%0b exp=1", busy[ch]); n_mis++; end n_cmp++;
    tick();
    if (busy[ch] !== 1'b0) begin $display("FAIL lat_busy_fall act=%0b exp=0", busy[ch]); n_mis++; end n_cmp++;
    stall[ch] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_busy_drop();
    int ch = TX_OFM_DONE;
    int unsigned e0 = edge_cnt[ch];
    stall[ch] = 1'b1; ack_frc[ch] = 1'b0;
    pulse(ch);
    tick();
    pulse(ch);
    if (get_pend(ch) !== (QUEUE ? 1 : 0)) begin $display("FAIL drop_pend act=%0d exp=%0d", get_pend(ch), QUEUE ? 1 : 0); n_mis++; end n_cmp++;
    if (ovf[ch] !== !QUEUE) begin $display("FAIL drop_ovf act=%0b exp=%0b", ovf[ch], !QUEUE); n_mis++; end n_cmp++;
    drain(ch);
    if (edge_cnt[ch] - e0 !== (QUEUE ? 2 : 1)) begin $display("FAIL drop_edges act=%0d exp=%0d", edge_cnt[ch] - e0, QUEUE ? 2 : 1); n_mis++; end n_cmp++;
    clr_pulse();
    if (ovf !== '0) begin $display("FAIL drop_ovf_clr act=%0h exp=0", ovf); n_mis++; end n_cmp++;
  endtask

`ifdef SEU_NPU_EVT_TX_QUEUE_EN
  task automatic test_queue();
    int ch = WT_RST;
    int unsigned e0 = edge_cnt[ch];
    stall[ch] = 1'b1; ack_frc[ch] = 1'b0;
    pulse(ch);
    repeat (3) begin tick(); pulse(ch); end
    if (get_pend(ch) !== 3) begin $display("FAIL queue_pend act=%0d exp=3", get_pend(ch)); n_mis++; end n_cmp++;
    drain(ch);
    if (edge_cnt[ch] - e0 !== 4) begin $display("FAIL queue_edges act=%0d exp=4", edge_cnt[ch] - e0); n_mis++; end n_cmp++;
    if (get_pend(ch) !== 0) begin $display("FAIL queue_pend_end act=%0d exp=0", get_pend(ch)); n_mis++; end n_cmp++;
    if (ovf[ch] !== 1'b0) begin $display("FAIL queue_ovf act=%0b exp=0", ovf[ch]); n_mis++; end n_cmp++;
  endtask

  task automatic test_overflow();
    int ch = WT_RST;
    int unsigned e0 = edge_cnt[ch];
    stall[ch] = 1'b1; ack_frc[ch] = 1'b0;
    pulse(ch);
    repeat (5) pulse(ch);
    if (get_pend(ch) !== PMAX) begin $display("FAIL ovf_pend act=%0d exp=%0d", get_pend(ch), PMAX); n_mis++; end n_cmp++;
    if (ovf[ch] !== 1'b1) begin $display("FAIL ovf_set act=%0b exp=1", ovf[ch]); n_mis++; end n_cmp++;
    clr_pulse();
    if (ovf[ch] !== 1'b0) begin $display("FAIL ovf_clr act=%0b exp=0", ovf[ch]); n_mis++; end n_cmp++;
    evt_pulse[ch] = 1'b1;
    clr_pulse();
    evt_pulse[ch] = 1'b0;
    if (ovf[ch] !== 1'b1) begin $display("FAIL ovf_set_wins act=%0b exp=1", ovf[ch]); n_mis++; end n_cmp++;
    if (get_pend(ch) !== PMAX) begin $display("FAIL ovf_pend_hold act=%0d exp=%0d", get_pend(ch), PMAX); n_mis++; end n_cmp++;
    drain(ch);
    if (edge_cnt[ch] - e0 !== 1 + PMAX) begin $display("FAIL ovf_edges act=%0d exp=%0d", edge_cnt[ch] - e0, 1 + PMAX); n_mis++; end n_cmp++;
    clr_pulse();
  endtask

  task automatic test_consume_evt();
    int ch = FIRST_BN;
    int n = 0;
    int unsigned e0 = edge_cnt[ch];
    stall[ch] = 1'b1; ack_frc[ch] = 1'b0;
    pulse(ch);
    pulse(ch);
    ack_frc[ch] = 1'b1;
    while (req_lvl[ch] && n < 50) begin tick(); n++; end
    if (n >= 50) begin $display("FAIL consume_rel_timeout act=1 exp=0"); n_mis++; end n_cmp++;
    ack_frc[ch] = 1'b0;
    repeat (2) tick();
    if (get_pend(ch) !== 1) begin $display("FAIL consume_pend_pre act=%0d exp=1", get_pend(ch)); n_mis++; end n_cmp++;
    pulse(ch);
    if (req_lvl[ch] !== 1'b1) begin $display("FAIL consume_reissue act=%0b exp=1", req_lvl[ch]); n_mis++; end n_cmp++;
    if (busy[ch] !== 1'b1) begin $display("FAIL consume_busy act=%0b exp=1", busy[ch]); n_mis++; end n_cmp++;
    if (get_pend(ch) !== 1) begin $display("FAIL consume_pend act=%0d exp=1", get_pend(ch)); n_mis++; end n_cmp++;
    drain(ch);
    if (edge_cnt[ch] - e0 !== 3) begin $display("FAIL consume_edges act=%0d exp=3", edge_cnt[ch] - e0); n_mis++; end n_cmp++;
  endtask
`endif

  // Random channel and burst length during a stalled handshake, checked by counting.
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int ch = int'($urandom_range(0, NCH - 1));
      int k  = int'($urandom_range(0, 6));
      int unsigned e0 = edge_cnt[ch];
      int unsigned q  = QUEUE ? ((k > int'(PMAX)) ? PMAX : k) : 0;
      bit exp_ovf = QUEUE ? (k > int'(PMAX)) : (k > 0);
      stall[ch] = 1'b1; ack_frc[ch] = 1'b0;
      pulse(ch);
      if (req_lvl[ch] !== 1'b1) begin $display("FAIL rnd_req it=%0d act=%0b exp=1", it, req_lvl[ch]); n_mis++; end n_cmp++;
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        pulse(ch);
      end
      if (get_pend(ch) !== q) begin $display("FAIL rnd_pend it=%0d ch=%0d act=%0d exp=%0d", it, ch, get_pend(ch), q); n_mis++; end n_cmp++;
      if (ovf[ch] !== exp_ovf) begin $display("FAIL rnd_ovf it=%0d ch=%0d act=%0b exp=%0b", it, ch, ovf[ch], exp_ovf); n_mis++; end n_cmp++;
      drain(ch);
      if (edge_cnt[ch] - e0 !== 1 + q) begin $display("FAIL rnd_edges it=%0d ch=%0d act=%0d exp=%0d", it, ch, edge_cnt[ch] - e0, 1 + q); n_mis++; end n_cmp++;
      if (get_pend(ch) !== 0) begin $display("FAIL rnd_pend_end it=%0d act=%0d exp=0", it, get_pend(ch)); n_mis++; end n_cmp++;
      clr_pulse();
      if (ovf !== '0) begin $display("FAIL rnd_ovf_clr it=%0d act=%0h exp=0", it, ovf); n_mis++; end n_cmp++;
    end
  endtask

  task automatic test_reset_mid();
    int ch = CAL_START;
    int unsigned e0;
    stall[ch] = 1'b1; ack_frc[ch] = 1'b0;
    pulse(ch);
    pulse(ch);
    ack_frc[ch] = 1'b1;
    rst_n = 1'b0;
    #1;
    if ({req_lvl, busy, ovf, pend_cnt} !== '0) begin $display("FAIL rstmid_outputs act=%0h exp=0", {req_lvl, busy, ovf, pend_cnt}); n_mis++; end n_cmp++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    e0 = edge_cnt[ch];
    pulse(ch);
    repeat (4) tick();
    if (req_lvl[ch] !== 1'b0) begin $display("FAIL rstmid_stale_ack act=%0b exp=0", req_lvl[ch]); n_mis++; end n_cmp++;
    if (get_pend(ch) !== (QUEUE ? 1 : 0)) begin $display("FAIL rstmid_pend act=%0d exp=%0d", get_pend(ch), QUEUE ? 1 : 0); n_mis++; end n_cmp++;
    ack_frc[ch] = 1'b0;
    repeat (2) tick();
    if (req_lvl[ch] !== 1'b0) begin $display("FAIL rstmid_early act=%0b exp=0", req_lvl[ch]); n_mis++; end n_cmp++;
    tick();
    if (req_lvl[ch] !== QUEUE) begin $display("FAIL rstmid_replay act=%0b exp=%0b", req_lvl[ch], QUEUE); n_mis++; end n_cmp++;
    if (!QUEUE) begin
      if (ovf[ch] !== 1'b1) begin $display("FAIL rstmid_drop_ovf act=%0b exp=1", ovf[ch]); n_mis++; end n_cmp++;
      pulse(ch);
      if (req_lvl[ch] !== 1'b1) begin $display("FAIL rstmid_new_req act=%0b exp=1", req_lvl[ch]); n_mis++; end n_cmp++;
    end
    drain(ch);
    if (edge_cnt[ch] - e0 !== 1) begin $display("FAIL rstmid_edges act=%0d exp=1", edge_cnt[ch] - e0); n_mis++; end n_cmp++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ack_latency();
    test_busy_drop();
`ifdef SEU_NPU_EVT_TX_QUEUE_EN
    test_queue();
    test_overflow();
    test_consume_evt();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
